// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-entry in-order FIFO.
// Optional INST_FETCH_MISALIGN_CHECK_EN: misaligned redirect sets sticky o_misalign and halts fetch.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_inst,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_misalign
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                misalign_q, misalign_d;
  logic [1:0]          count_q, count_d;
  logic                head_q, head_d;
  logic [INST_W-1:0]   inst_mem_q [2];
  logic [INST_W-1:0]   inst_mem_d [2];
  logic [ADDR_W-1:0]   pc_mem_q [2];
  logic [ADDR_W-1:0]   pc_mem_d [2];

  logic [ADDR_W-1:0]   redirect_pc;
  logic                bad_target;
  logic                fifo_valid;
  logic                push;
  logic                pop;
  logic                wr_idx;

`ifdef INST_FETCH_MISALIGN_CHECK_EN
  assign redirect_pc = i_redirect_pc;
  assign bad_target  = i_redirect && (i_redirect_pc[1:0] != 2'b00);
`else
  assign redirect_pc = i_redirect_pc & ~ADDR_W'(3);
  assign bad_target  = 1'b0;
`endif

  assign fifo_valid = (count_q != 2'd0);
  assign pop        = fifo_valid && i_inst_ready;
  assign push       = (state_q == S_WAIT) && i_imem_valid && !drop_q && !i_redirect && !misalign_q;
  assign wr_idx     = head_q ^ count_q[0];

  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    misalign_d = misalign_q | bad_target;
    if (i_redirect) begin
      count_d = '0;
      head_d  = 1'b0;
    end else begin
      if (push) begin
        inst_mem_d[wr_idx] = i_imem_inst;
        pc_mem_d[wr_idx]   = pc_q - ADDR_W'(4);
      end
      if (pop) head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // A redirect that coincides with the outstanding response consumes it, so no drop is left pending.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    if (misalign_q) begin
      state_d = state_q;
    end else if (i_redirect) begin
      pc_d = redirect_pc;
      unique case (state_q)
        S_REQ: begin
          state_d = S_WAIT;
          drop_d  = 1'b1;
        end
        S_WAIT: begin
          if (i_imem_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          state_d = S_WAIT;
          pc_d    = pc_q + ADDR_W'(4);
        end
        S_WAIT: begin
          if (i_imem_valid) begin
            drop_d  = 1'b0;
            state_d = (!drop_q && count_d == 2'd2) ? S_FULL : S_REQ;
          end
        end
        default: if (pop) state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
      head_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge i_clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  always_comb begin
    o_imem_req   = 1'b0;
    o_imem_addr  = '0;
    o_inst_valid = 1'b0;
    o_inst       = '0;
    o_inst_pc    = '0;
    o_misalign   = 1'b0;
    if (!i_rst) begin
      o_misalign = misalign_q;
      if (state_q == S_REQ && !misalign_q) begin
        o_imem_req  = 1'b1;
        o_imem_addr = pc_q;
      end
      if (fifo_valid) begin
        o_inst_valid = 1'b1;
        o_inst       = inst_mem_q[head_q];
        o_inst_pc    = pc_mem_q[head_q];
      end
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; INST_W, default 32, instruction width; RESET_PC, default 0, first fetch address.
REQ-002 Ports SHALL be:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset, sampled on the rising edge of i_clk.
- o_imem_req  out  1  instruction-memory request pulse.
- o_imem_addr  out  ADDR_W  request address.
- i_imem_valid  in  1  response valid.
- i_imem_inst  in  INST_W  response instruction.
- o_inst_valid  out  1  decode-side instruction valid.
- o_inst  out  INST_W  instruction to decode/immediate generation.
- o_inst_pc  out  ADDR_W  PC of o_inst.
- i_inst_ready  in  1  decode accepts o_inst.
- i_redirect  in  1  branch/jump redirect.
- i_redirect_pc  in  ADDR_W  redirect target.
- o_misalign  out  1  sticky misaligned-target flag.
REQ-003 Clock SHALL be one clock, i_clk; reset SHALL be synchronous and active-high, i_rst.

Function
REQ-004 The FSM SHALL have the states S_REQ, S_WAIT and S_FULL, with at most one memory request outstanding.
REQ-005 o_imem_req SHALL be registered and equal to 1 exactly while in S_REQ, with o_imem_addr = pc.
REQ-006 S_REQ SHALL always go to S_WAIT after one cycle, with pc <= pc + 4 (mod 2^ADDR_W, wrap silent).
REQ-007 In S_WAIT, i_imem_valid SHALL write {i_imem_inst, pc - 4} into a 2-entry FIFO and go to S_REQ if a slot remains free after that cycle's push/pop, else to S_FULL.
REQ-008 S_FULL SHALL go to S_REQ in the cycle after a pop frees a slot.
REQ-009 i_imem_valid outside S_WAIT SHALL be ignored.
REQ-010 Memory latency SHALL be at least 1 cycle; minimum issue rate is one request per 2 cycles.
REQ-011 o_inst_valid SHALL be 1 when the FIFO is non-empty; o_inst and o_inst_pc SHALL show the head entry, and are 0 when empty.
REQ-012 A pushed entry SHALL become visible on the next cycle; FIFO fall-through is not allowed.
REQ-013 A pop SHALL occur when o_inst_valid && i_inst_ready.
REQ-014 Push and pop in the same cycle SHALL keep the occupancy unchanged; instruction order SHALL be preserved.
REQ-015 i_redirect SHALL flush the FIFO (o_inst_valid = 0 next cycle) and load pc <= i_redirect_pc.
REQ-016 Redirect SHALL win over a same-cycle pop, push or response.
REQ-017 Redirect in S_REQ or S_WAIT SHALL set a drop flag: the outstanding response is discarded, then S_REQ issues the new pc.
REQ-018 Redirect in S_FULL SHALL go to S_REQ.
REQ-019 Redirect-to-request latency with nothing outstanding SHALL be 1 cycle.
REQ-020 Back-to-back redirects SHALL leave the last target in force, with only one drop pending.

Reset
REQ-021 i_rst SHALL set pc = RESET_PC, state = S_REQ, FIFO empty, drop flag = 0 and o_misalign = 0; all outputs SHALL be 0 during reset.
REQ-022 The first cycle after i_rst deasserts SHALL assert o_imem_req with o_imem_addr = RESET_PC.
REQ-023 Reset mid-transfer SHALL abandon any outstanding response, which is ignored because state is S_REQ without a drop flag.

Configuration
REQ-024 With INST_FETCH_MISALIGN_CHECK_EN defined, a redirect with i_redirect_pc[1:0] != 0 SHALL:
- set o_misalign (sticky until i_rst);
- flush the FIFO;
- issue no further requests until reset.
REQ-025 Without INST_FETCH_MISALIGN_CHECK_EN, i_redirect_pc[1:0] SHALL be forced to 0 and o_misalign tied to 0.

Verification
REQ-026 Reset release, memory latency 1, ready=1 -> requests at 0x0, 0x4, 0x8 every 2 cycles; o_inst_pc sequence 0x0, 0x4, 0x8 with matching instructions.
REQ-027 i_inst_ready=0, responses 0x00000013 and 0x00100093 -> FIFO full, state S_FULL, no third request; ready=1 for one cycle -> request at 0x8 the following cycle.
REQ-028 Redirect to 0x100 while in S_WAIT (latency 3) -> stale response dropped, o_inst_valid stays 0, next request addr 0x100.
REQ-029 Redirect to 0x200 in the same cycle as pop and response -> FIFO empty next cycle, next request addr 0x200, response not delivered.
REQ-030 With the macro defined, redirect to 0x102 -> o_misalign=1, no o_imem_req until i_rst; without the macro -> request addr 0x100.
REQ-031 pc = 2^ADDR_W-4 fetched -> next request addr 0x0, no error.
